// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory stage of the 8-bit
// pipelined processor.
//   - mem_state_t   : data-memory access FSM states
//   - WB_SEL_*      : writeback source select codes (mux_rdata_sel_M)
//   - PC_SEL_RESET  : PC select value after reset, matching EX/MEM reset
//   - DMEM_ERR_DATA : read data substituted when an access times out
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_INP = 2'b10;
  localparam logic [1:0] WB_SEL_WD  = 2'b11;

  localparam logic [1:0] PC_SEL_RESET = 2'b01;

  localparam logic [7:0] DMEM_ERR_DATA = 8'hFF;

endpackage

// File: rtl/mem_stage_unit_wb.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion.
// While i_stall is high the control bits (write enable, return-valid) are
// cleared and the data fields hold; otherwise all fields load from M.
// The return-PC field loads only on i_ret_load, and return-valid is a
// single-cycle pulse.
// Ports:
//   clk, reset (async, active-low)
//   i_stall            : insert bubble this edge
//   i_wr_en, i_rd      : register-file write enable / destination
//   i_wb_data          : selected writeback data
//   i_pc_sel           : PC select passed through
//   i_ret_load         : load return PC and pulse return-valid
//   i_ret_pc           : popped return PC
//   o_*                : registered MEM/WB outputs
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stall,
  input  logic              i_wr_en,
  input  logic [1:0]        i_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [1:0]        i_pc_sel,
  input  logic              i_ret_load,
  input  logic [DATA_W-1:0] i_ret_pc,
  output logic              o_wr_en,
  output logic [1:0]        o_rd,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [1:0]        o_pc_sel,
  output logic              o_ret_valid,
  output logic [DATA_W-1:0] o_ret_pc
);

  logic              r_wr_en;
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [1:0]        r_pc_sel;
  logic              r_ret_valid;
  logic [DATA_W-1:0] r_ret_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en     <= 1'b0;
      r_rd        <= '0;
      r_wb_data   <= '0;
      r_pc_sel    <= PC_SEL_RESET;
      r_ret_valid <= 1'b0;
      r_ret_pc    <= '0;
    end else begin
      r_ret_valid <= i_ret_load & ~i_stall;
      if (i_ret_load & ~i_stall) begin
        r_ret_pc <= i_ret_pc;
      end
      if (i_stall) begin
        r_wr_en <= 1'b0;
      end else begin
        r_wr_en   <= i_wr_en;
        r_rd      <= i_rd;
        r_wb_data <= i_wb_data;
        r_pc_sel  <= i_pc_sel;
      end
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_rd        = r_rd;
  assign o_wb_data   = r_wb_data;
  assign o_pc_sel    = r_pc_sel;
  assign o_ret_valid = r_ret_valid;
  assign o_ret_pc    = r_ret_pc;

endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: memory stage of the 8-bit pipelined processor.
// Consumes the EX/MEM register outputs, runs the data-memory access over a
// req/ack handshake (stalling the pipeline while in flight, with a timeout
// abort), drives the OUT port register and produces the MEM/WB register.
// Ports:
//   clk, reset (async, active-low)
//   *_M                      : EX/MEM control and data inputs
//   dmem_req/we/addr/wdata   : memory request side
//   dmem_rdata, dmem_ack     : memory response (one-cycle ack pulse)
//   mem_stall                : freezes PC, IF/ID, ID/EX, EX/MEM
//   OUT_PORT                 : output port register
//   *_W, ret_pc_W/ret_valid_W: MEM/WB outputs
//   mem_err                  : sticky timeout flag
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_regf_M,
  input  logic              wr_en_dmem_M,
  input  logic              rd_en_M,
  input  logic              out_port_sel_M,
  input  logic              is_ret_M,
  input  logic [1:0]        mux_rdata_sel_M,
  input  logic [DATA_W-1:0] alu_out_M,
  input  logic [1:0]        rd_M,
  input  logic [DATA_W-1:0] IN_PORT_M,
  input  logic [ADDR_W-1:0] mem_addr_M,
  input  logic [DATA_W-1:0] mem_wd_M,
  input  logic [1:0]        PC_Sel_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              wr_en_regf_W,
  output logic [1:0]        rd_W,
  output logic [DATA_W-1:0] wb_data_W,
  output logic [1:0]        PC_Sel_W,
  output logic [DATA_W-1:0] ret_pc_W,
  output logic              ret_valid_W,
  output logic              mem_err
);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata_q;
  logic              r_mem_err;
  logic [DATA_W-1:0] r_out_port;

  logic              w_access;
  logic              w_req;
  logic              w_stall;
  logic              w_timeout;
  logic              w_ret_load;
  logic [DATA_W-1:0] w_wb_mux;

  assign w_access = rd_en_M | wr_en_dmem_M;

  always_comb begin
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_timeout   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        // An ack on the final allowed WAIT cycle still completes normally.
        if (dmem_ack) begin
          w_state_nxt = DONE;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // The retiring instruction is still on the M inputs here; going
        // straight to IDLE without looking at access prevents a reissue.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Request and stall must drop the instant reset asserts, even though
    // IDLE would otherwise raise them combinationally from the M inputs.
    if (!reset) begin
      w_req   = 1'b0;
      w_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_rdata_q <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (r_state == WAIT && w_state_nxt == WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end
      if (r_state == WAIT && dmem_ack) begin
        r_rdata_q <= dmem_rdata;
      end else if (w_timeout) begin
        r_rdata_q <= DATA_W'(DMEM_ERR_DATA);
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_port <= '0;
    end else if (out_port_sel_M && !w_stall) begin
      r_out_port <= alu_out_M;
    end
  end

  always_comb begin
    w_wb_mux = alu_out_M;
    case (mux_rdata_sel_M)
      WB_SEL_ALU: w_wb_mux = alu_out_M;
      WB_SEL_MEM: w_wb_mux = r_rdata_q;
      WB_SEL_INP: w_wb_mux = IN_PORT_M;
      WB_SEL_WD:  w_wb_mux = mem_wd_M;
      default:    w_wb_mux = alu_out_M;
    endcase
  end

  assign w_ret_load = is_ret_M & rd_en_M & (r_state == DONE);

  mem_wb_reg #(
    .DATA_W(DATA_W)
  ) u_mem_wb_reg (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (w_stall),
    .i_wr_en    (wr_en_regf_M),
    .i_rd       (rd_M),
    .i_wb_data  (w_wb_mux),
    .i_pc_sel   (PC_Sel_M),
    .i_ret_load (w_ret_load),
    .i_ret_pc   (r_rdata_q),
    .o_wr_en    (wr_en_regf_W),
    .o_rd       (rd_W),
    .o_wb_data  (wb_data_W),
    .o_pc_sel   (PC_Sel_W),
    .o_ret_valid(ret_valid_W),
    .o_ret_pc   (ret_pc_W)
  );

  assign dmem_req   = w_req;
  assign dmem_we    = w_req & wr_en_dmem_M;
  assign dmem_addr  = w_req ? mem_addr_M : '0;
  assign dmem_wdata = w_req ? mem_wd_M : '0;
  assign mem_stall  = w_stall;
  assign OUT_PORT   = r_out_port;
  assign mem_err    = r_mem_err;

endmodule
